btb_controller: RTL and testbench

- Owns and sequences the 16-entry branch target buffer with 2-bit saturating counters, serving fetch-stage lookups and execute-stage resolve updates.
- Storage is single-ported: one lookup or one update per cycle; the controller arbitrates between the two.
- Also runs the post-reset and post-flush clear sequence.
- Sits between the fetch PC mux (lookup side) and the branch-resolution logic in execute (update side).

---
 rtl/chronos_bp_pkg.sv | 56 +++++
 rtl/btb_storage.sv | 26 ++
 rtl/btb_controller.sv | 199 +++++++++++++++++++
 tb/tb_btb_controller.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chronos_bp_pkg.sv
// Shared branch-predictor types: BTB entry layout, counter encodings, controller states.
// Also holds the PC index/tag split and the 2-bit counter update rule.
package chronos_bp_pkg;

   localparam int unsigned BtbEntries = 16;
   localparam int unsigned BtbIdxW    = $clog2(BtbEntries);
   localparam int unsigned BtbTagW    = 32 - BtbIdxW - 2;
   localparam int unsigned BtbQDepth  = 2;

   typedef enum logic [1:0] {
      CtrSnt = 2'b00,
      CtrWnt = 2'b01,
      CtrWt  = 2'b10,
      CtrSt  = 2'b11
   } ctr_e;

   typedef enum logic {
      StInit,
      StRun
   } ctrl_state_e;

   typedef struct packed {
      logic               valid;
      logic [BtbTagW-1:0] tag;
      logic [31:0]        target;
      ctr_e               ctr;
   } btb_entry_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } resolve_req_t;

   function automatic logic [BtbIdxW-1:0] pc_idx(input logic [31:0] pc);
      return pc[BtbIdxW+1:2];
   endfunction

   function automatic logic [BtbTagW-1:0] pc_tag(input logic [31:0] pc);
      return pc[31:BtbIdxW+2];
   endfunction

   function automatic ctr_e ctr_update(input ctr_e ctr, input logic taken);
      ctr_e res;
      res = ctr;
      unique case (ctr)
         CtrSnt: res = taken ? CtrWnt : CtrSnt;
         CtrWnt: res = taken ? CtrWt  : CtrSnt;
         CtrWt:  res = taken ? CtrSt  : CtrWnt;
         CtrSt:  res = taken ? CtrSt  : CtrWt;
         default: res = ctr;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/btb_storage.sv
// BTB register file: one combinational read port and one write port sharing a single index.
// No reset; the controller's clear sequence initialises every entry.
module btb_storage
   import chronos_bp_pkg::*;
#(
   parameter int unsigned Entries = BtbEntries,
   parameter int unsigned IdxW    = BtbIdxW
) (
   input  logic            clk_i,
   input  logic [IdxW-1:0] idx_i,
   input  logic            we_i,
   input  btb_entry_t      wdata_i,
   output btb_entry_t      rdata_o
);

   btb_entry_t mem_q [Entries];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/btb_controller.sv
// BTB controller: arbitrates single-ported storage between fetch lookups and queued
// resolve updates, and sequences the post-reset / post-flush clear.
module btb_controller
   import chronos_bp_pkg::*;
#(
   parameter int unsigned ENTRIES = BtbEntries,
   parameter int unsigned IDX_W   = BtbIdxW,
   parameter int unsigned QDEPTH  = BtbQDepth
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        lookup_valid,
   input  logic [31:0] lookup_pc,
   output logic        lookup_ready,
   output logic        pred_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        resolve_valid,
   input  logic [31:0] resolve_pc,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_target,
   output logic        resolve_ready,
   output logic        busy
);

   localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CntW = $clog2(QDEPTH + 1);

   ctrl_state_e state_q, state_d;
   logic [IDX_W-1:0] clear_idx_q, clear_idx_d;

   resolve_req_t     q_mem_q [QDEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q, cnt_d;
   resolve_req_t     q_head;
   logic             q_full, q_empty, push, pop;

   logic        pred_valid_q, pred_valid_d;
   logic        pred_taken_q, pred_taken_d;
   logic [31:0] pred_target_q, pred_target_d;

   logic [IDX_W-1:0] st_idx;
   logic             st_we;
   btb_entry_t       st_wdata, st_rdata;

   logic do_lookup, do_update, lk_hit, upd_hit;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(QDEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   btb_storage #(
      .Entries (ENTRIES),
      .IdxW    (IDX_W)
   ) u_storage (
      .clk_i   (clk),
      .idx_i   (st_idx),
      .we_i    (st_we),
      .wdata_i (st_wdata),
      .rdata_o (st_rdata)
   );

   assign q_head  = q_mem_q[rd_ptr_q];
   assign q_full  = (cnt_q == CntW'(QDEPTH));
   assign q_empty = (cnt_q == '0);
   assign busy    = (state_q == StInit);

   always_comb begin
      state_d       = state_q;
      clear_idx_d   = clear_idx_q;
      lookup_ready  = 1'b0;
      resolve_ready = 1'b0;
      do_lookup     = 1'b0;
      do_update     = 1'b0;
      lk_hit        = 1'b0;
      upd_hit       = 1'b0;
      st_idx        = pc_idx(lookup_pc);
      st_we         = 1'b0;
      st_wdata      = '0;
      pred_valid_d  = 1'b0;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;

      unique case (state_q)
         StInit: begin
            st_idx       = clear_idx_q;
            st_we        = 1'b1;
            st_wdata.ctr = CtrWnt;
            clear_idx_d  = clear_idx_q + 1'b1;
            if (clear_idx_q == IDX_W'(ENTRIES - 1)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (!flush) begin
               lookup_ready  = !q_full;
               resolve_ready = !q_full;
               // A full queue takes the port so resolves can never be starved by fetch.
               do_update     = q_full || (!lookup_valid && !q_empty);
               do_lookup     = !q_full && lookup_valid;
            end
         end
         default: state_d = StInit;
      endcase

      if (do_lookup) begin
         lk_hit        = st_rdata.valid && (st_rdata.tag == pc_tag(lookup_pc));
         pred_valid_d  = 1'b1;
         pred_taken_d  = lk_hit && st_rdata.ctr[1];
         pred_target_d = pred_taken_d ? st_rdata.target : lookup_pc + 32'd4;
      end

      if (do_update) begin
         st_idx  = pc_idx(q_head.pc);
         upd_hit = st_rdata.valid && (st_rdata.tag == pc_tag(q_head.pc));
         if (upd_hit) begin
            st_we        = 1'b1;
            st_wdata     = st_rdata;
            st_wdata.ctr = ctr_update(st_rdata.ctr, q_head.taken);
            if (q_head.taken) begin
               st_wdata.target = q_head.target;
            end
         end else if (q_head.taken) begin
            st_we           = 1'b1;
            st_wdata.valid  = 1'b1;
            st_wdata.tag    = pc_tag(q_head.pc);
            st_wdata.target = q_head.target;
            st_wdata.ctr    = CtrWt;
         end
      end

      if (flush) begin
         state_d     = StInit;
         clear_idx_d = '0;
      end
   end

   assign push = resolve_valid && resolve_ready;
   assign pop  = do_update;

   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StInit;
         clear_idx_q <= '0;
      end else begin
         state_q     <= state_d;
         clear_idx_q <= clear_idx_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_mem_q[wr_ptr_q] <= '{pc: resolve_pc, taken: resolve_taken, target: resolve_target};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
      end else begin
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
      end
   end

   assign pred_valid  = pred_valid_q;
   assign pred_taken  = pred_taken_q;
   assign pred_target = pred_target_q;

endmodule

// File: tb/tb_btb_controller.sv
// Randomised scoreboard bench for btb_controller against an array/queue reference model.
module tb_btb_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        lookup_ready;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        resolve_valid;
   logic [31:0] resolve_pc;
   logic        resolve_taken;
   logic [31:0] resolve_target;
   logic        resolve_ready;
   logic        busy;

   always #5 clk = ~clk;

   btb_controller dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .lookup_valid   (lookup_valid),
      .lookup_pc      (lookup_pc),
      .lookup_ready   (lookup_ready),
      .pred_valid     (pred_valid),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .resolve_valid  (resolve_valid),
      .resolve_pc     (resolve_pc),
      .resolve_taken  (resolve_taken),
      .resolve_target (resolve_target),
      .resolve_ready  (resolve_ready),
      .busy           (busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: plain arrays for the table, a queue for pending resolves.
   typedef struct {
      logic [31:0] pc;
      bit          taken;
      logic [31:0] target;
   } res_t;
   typedef struct {
      bit          taken;
      logic [31:0] target;
   } pred_t;

   bit          m_valid  [16];
   logic [31:0] m_tag    [16];
   logic [31:0] m_target [16];
   int          m_ctr    [16];
   int          init_cnt;
   res_t        mq [$];
   pred_t       sb [$];

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc >> 2) % 16);
   endfunction

   function automatic void model_lookup(input logic [31:0] pc);
      int    i;
      bit    hit;
      pred_t p;
      i        = idx_of(pc);
      hit      = m_valid[i] && (m_tag[i] == (pc >> 6));
      p.taken  = hit && (m_ctr[i] >= 2);
      p.target = p.taken ? m_target[i] : pc + 32'd4;
      sb.push_back(p);
   endfunction

   function automatic void model_update();
      res_t r;
      int   i;
      r = mq.pop_front();
      i = idx_of(r.pc);
      if (m_valid[i] && (m_tag[i] == (r.pc >> 6))) begin
         if (r.taken) begin
            m_ctr[i]    = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_target[i] = r.target;
         end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (r.taken) begin
         m_valid[i]  = 1'b1;
         m_tag[i]    = r.pc >> 6;
         m_target[i] = r.target;
         m_ctr[i]    = 2;
      end
   endfunction

   // Called between edges with inputs stable; checks handshakes, then advances the model.
   task automatic model_cycle();
      bit   run;
      int   sz;
      bit   push_ok;
      res_t r;
      run = (init_cnt == 16);
      sz  = mq.size();
      chk("busy", busy, !run);
      chk("lookup_ready", lookup_ready, run && sz < 2 && !flush);
      chk("resolve_ready", resolve_ready, run && sz < 2 && !flush);
      if (flush) begin
         init_cnt = 0;
         mq.delete();
      end else if (!run) begin
         m_valid[init_cnt] = 1'b0;
         m_ctr[init_cnt]   = 1;
         init_cnt++;
      end else begin
         push_ok = resolve_valid && (sz < 2);
         if (sz == 2) model_update();
         else if (lookup_valid) model_lookup(lookup_pc);
         else if (sz > 0) model_update();
         if (push_ok) begin
            r.pc     = resolve_pc;
            r.taken  = resolve_taken;
            r.target = resolve_target;
            mq.push_back(r);
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      lookup_valid  = 1'b0;
      resolve_valid = 1'b0;
      flush         = 1'b0;
      repeat (n) step();
   endtask

   task automatic do_lookup(input logic [31:0] pc);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      step();
      lookup_valid = 1'b0;
   endtask

   task automatic do_resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
      resolve_valid  = 1'b1;
      resolve_pc     = pc;
      resolve_taken  = t;
      resolve_target = tgt;
      step();
      resolve_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      lookup_valid  = 1'b0;
      resolve_valid = 1'b0;
      while (mq.size() != 0 && guard < 8) begin
         step();
         guard++;
      end
      chk("drain_bound", mq.size(), 0);
   endtask

   // Monitor: pops one expected prediction per DUT pred_valid.
   initial begin
      pred_t p;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && pred_valid) begin
            if (sb.size() == 0) begin
               chk("pred_unexpected", pred_valid, 0);
            end else begin
               p = sb.pop_front();
               chk("pred_taken", pred_taken, p.taken);
               chk("pred_target", pred_target, p.target);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rand_pc();
      logic [31:0] t, i;
      if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
      t = $urandom_range(0, 2);
      i = $urandom_range(0, 3);
      return (t << 6) | (i << 2);
   endfunction

   initial begin
      rst            = 1'b1;
      flush          = 1'b0;
      lookup_valid   = 1'b0;
      lookup_pc      = '0;
      resolve_valid  = 1'b0;
      resolve_pc     = '0;
      resolve_taken  = 1'b0;
      resolve_target = '0;
      init_cnt       = 0;
      #1;
      chk("rst_pred_valid", pred_valid, 0);
      chk("rst_pred_taken", pred_taken, 0);
      chk("rst_pred_target", pred_target, 0);
      chk("rst_busy", busy, 1);
      chk("rst_lookup_ready", lookup_ready, 0);
      chk("rst_resolve_ready", resolve_ready, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Clear sequence, then cold lookup and wrap-around.
      idle(16);
      do_lookup(32'h100);
      do_lookup(32'hFFFF_FFFC);
      idle(1);

      // Training and counter saturation.
      do_resolve(32'h100, 1'b1, 32'h200);
      drain();
      do_lookup(32'h100);
      do_resolve(32'h100, 1'b0, 32'h0);
      do_resolve(32'h100, 1'b0, 32'h0);
      drain();
      do_lookup(32'h100);
      do_resolve(32'h100, 1'b0, 32'h0);
      drain();
      do_lookup(32'h100);

      // Alias: same index, different tag.
      do_resolve(32'h100, 1'b1, 32'h300);
      do_resolve(32'h100, 1'b1, 32'h300);
      drain();
      do_lookup(32'h100);
      do_lookup(32'h140);

      // Fill the queue with a lookup held high.
      lookup_valid   = 1'b1;
      lookup_pc      = 32'h100;
      resolve_valid  = 1'b1;
      resolve_pc     = 32'h104;
      resolve_taken  = 1'b1;
      resolve_target = 32'h500;
      step();
      resolve_pc = 32'h108;
      step();
      resolve_valid = 1'b0;
      repeat (3) step();
      drain();

      // Flush with a trained entry and one queued update.
      do_resolve(32'h180, 1'b1, 32'h400);
      drain();
      lookup_valid   = 1'b1;
      lookup_pc      = 32'h180;
      resolve_valid  = 1'b1;
      resolve_pc     = 32'h1C0;
      resolve_taken  = 1'b1;
      resolve_target = 32'h440;
      step();
      flush = 1'b1;
      step();
      idle(16);
      do_lookup(32'h180);
      idle(1);

      // Async reset between edges while a prediction is being presented.
      do_lookup(32'h100);
      #1;
      rst = 1'b1;
      #1;
      chk("async_pred_valid", pred_valid, 0);
      chk("async_pred_target", pred_target, 0);
      chk("async_busy", busy, 1);
      sb.delete();
      mq.delete();
      init_cnt = 0;
      #1;
      rst = 1'b0;
      idle(16);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         flush          = ($urandom_range(0, 99) == 0);
         lookup_valid   = ($urandom_range(0, 1) == 1);
         lookup_pc      = rand_pc();
         resolve_valid  = ($urandom_range(0, 4) < 2);
         resolve_pc     = rand_pc();
         resolve_taken  = ($urandom_range(0, 2) != 0);
         resolve_target = $urandom & 32'hFFFF_FFFC;
         step();
      end
      idle(20);
      chk("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
